// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin arbiter steering N valid/ready requesters onto one downstream port
// Define ARB_BURST_EN to let a grant carry up to BURST back-to-back transfers.
module mux_arbiter #(
   parameter int N     = 8,
   parameter int W     = 32,
   parameter int BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_valid,
   input  logic [N*W-1:0]       req_data,
   output logic [N-1:0]         req_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] grant_sel,
   output logic                 grant_active
);
   localparam int SEL_W = $clog2(N);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           r_state, w_next_state;
   logic [SEL_W-1:0] r_grant_sel, w_next_sel;
   logic [SEL_W-1:0] r_ptr, w_next_ptr;
   logic [SEL_W-1:0] w_idx, w_winner;
   logic             w_found;
   logic             w_sel_valid;
`ifdef ARB_BURST_EN
   logic [3:0]       r_burst_cnt, w_next_cnt;
`endif

   if (N < 2 || N > 32 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("mux_arbiter: N must be a power of two in 2..32");
   end
   if (BURST < 1 || BURST > 16) begin : g_bad_burst
      $error("mux_arbiter: BURST must be in 1..16");
   end

   // Search upward from ptr; N is a power of two so SEL_W-bit addition wraps for free.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = r_ptr;
      for (int k = 0; k < N; k++) begin
         w_idx = r_ptr + SEL_W'(k);
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_comb begin
      out_data = req_data[0 +: W];
      for (int i = 0; i < N; i++) begin
         if (SEL_W'(i) == r_grant_sel) out_data = req_data[i*W +: W];
      end
   end

   assign w_sel_valid = req_valid[r_grant_sel];
   assign grant_sel   = r_grant_sel;

   always_comb begin
      w_next_state = r_state;
      w_next_sel   = r_grant_sel;
      w_next_ptr   = r_ptr;
`ifdef ARB_BURST_EN
      w_next_cnt   = r_burst_cnt;
`endif
      out_valid    = 1'b0;
      req_ready    = '0;
      grant_active = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_next_sel   = w_winner;
               w_next_state = BUSY;
`ifdef ARB_BURST_EN
               w_next_cnt   = 4'd0;
`endif
            end
         end
         BUSY: begin
            grant_active           = 1'b1;
            out_valid              = w_sel_valid;
            req_ready[r_grant_sel] = out_ready;
            if (!w_sel_valid) begin
               // Withdrawal before any transfer keeps priority with this requester.
               w_next_state = IDLE;
`ifdef ARB_BURST_EN
               if (r_burst_cnt != 4'd0) w_next_ptr = r_grant_sel + SEL_W'(1);
`endif
            end else if (out_ready) begin
`ifdef ARB_BURST_EN
               if (r_burst_cnt < 4'(BURST - 1)) begin
                  w_next_cnt = r_burst_cnt + 4'd1;
               end else begin
                  w_next_ptr   = r_grant_sel + SEL_W'(1);
                  w_next_state = IDLE;
               end
`else
               w_next_ptr   = r_grant_sel + SEL_W'(1);
               w_next_state = IDLE;
`endif
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_grant_sel <= '0;
         r_ptr       <= '0;
`ifdef ARB_BURST_EN
         r_burst_cnt <= 4'd0;
`endif
      end else begin
         r_state     <= w_next_state;
         r_grant_sel <= w_next_sel;
         r_ptr       <= w_next_ptr;
`ifdef ARB_BURST_EN
         r_burst_cnt <= w_next_cnt;
`endif
      end
   end
endmodule
